// File: rtl/router_reg_gen.sv
// router_reg_gen: router input register stage between the router FSM and the
// per-port output FIFOs.
//   - Latches the packet header and forwards header and payload bytes on dout.
//   - Keeps the byte that arrives while the selected FIFO is full (hold) and
//     replays it in LOAD_AFTER_FULL.
//   - Accumulates a packet check value (XOR or modular sum), counts payload
//     bytes, compares both against the trailing check byte and the header
//     length field, and reports the result one cycle after parity_done rises.
//
// Ports:
//   clock, resetn            rising-edge clock, asynchronous active-low reset
//   pkt_valid                high for header/payload bytes, low on the check byte
//   fifo_full                selected output FIFO is full
//   rst_int_reg              FSM request to clear low_pkt_valid
//   detect_add, lfd_state,
//   ld_state, laf_state,
//   full_state               one-hot FSM state indications
//   data_in                  input byte
//   dout                     byte to the FIFO
//   parity_done              check byte has been captured
//   low_pkt_valid            pkt_valid has fallen within the current packet
//   err                      check or length mismatch
//   err_status               bit0 check mismatch, bit1 length mismatch
//   pay_cnt                  payload bytes accepted so far (saturating)
//
// Handshake: there is no ready path back to the source. A byte on data_in is
// consumed on a rising edge only in the FSM state that names it; while
// fifo_full is high in LOAD_DATA the byte is parked in hold and the FSM is
// expected to pass through FIFO_FULL_STATE and LOAD_AFTER_FULL to release it.
module router_reg_gen #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int NUM_PORTS = 3,
    parameter int CHK_MODE  = 0,
    parameter int LEN_CHECK = 1
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     pkt_valid,
    input  logic                     fifo_full,
    input  logic                     rst_int_reg,
    input  logic                     detect_add,
    input  logic                     lfd_state,
    input  logic                     ld_state,
    input  logic                     laf_state,
    input  logic                     full_state,
    input  logic [DATA_W-1:0]        data_in,
    output logic [DATA_W-1:0]        dout,
    output logic                     parity_done,
    output logic                     low_pkt_valid,
    output logic                     err,
    output logic [1:0]               err_status,
    output logic [DATA_W-ADDR_W-1:0] pay_cnt
);

    localparam int LEN_W = DATA_W - ADDR_W;

    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] chk_q, chk_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              parity_done_q, parity_done_d;
    logic              pd_prev_q, pd_prev_d;
    logic              low_pkt_valid_q, low_pkt_valid_d;
    logic              err_q, err_d;
    logic [1:0]        err_status_q, err_status_d;
    logic [LEN_W-1:0]  pay_cnt_q, pay_cnt_d;

    logic addr_ok;
    logic take_payload;
    logic pd_rise;

    // Running check operator: XOR parity or truncated modular sum.
    function automatic logic [DATA_W-1:0] acc_op(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        if (CHK_MODE == 1) return a + b;
        else               return a ^ b;
    endfunction

    assign addr_ok      = 32'(data_in[ADDR_W-1:0]) < 32'(NUM_PORTS);
    assign take_payload = ld_state && pkt_valid && !full_state;
    // The result is evaluated on the cycle after parity_done first goes high,
    // when acc and chk are both final.
    assign pd_rise      = parity_done_q && !pd_prev_q;

    always_comb begin
        hdr_d           = hdr_q;
        hold_d          = hold_q;
        acc_d           = acc_q;
        chk_d           = chk_q;
        dout_d          = dout_q;
        parity_done_d   = parity_done_q;
        pd_prev_d       = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;
        err_d           = err_q;
        err_status_d    = err_status_q;
        pay_cnt_d       = pay_cnt_q;

        // Invalid destinations keep the previous header.
        if (detect_add && pkt_valid && addr_ok) begin
            hdr_d = data_in;
        end

        if (lfd_state) begin
            dout_d = hdr_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (ld_state && fifo_full) begin
            hold_d = data_in;
        end else if (laf_state) begin
            dout_d = hold_q;
        end

        if (detect_add) begin
            acc_d = '0;
        end else if (lfd_state) begin
            acc_d = acc_op(acc_q, hdr_q);
        end else if (take_payload) begin
            acc_d = acc_op(acc_q, data_in);
        end

        if (detect_add) begin
            pay_cnt_d = '0;
        end else if (take_payload && (pay_cnt_q != '1)) begin
            pay_cnt_d = pay_cnt_q + LEN_W'(1);
        end

        // A check byte blocked by a full FIFO reaches chk through hold.
        if (ld_state && !pkt_valid && !fifo_full) begin
            chk_d = data_in;
        end else if (laf_state && !parity_done_q) begin
            chk_d = hold_q;
        end

        if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end

        if (detect_add) begin
            parity_done_d = 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid_q && !parity_done_q)) begin
            parity_done_d = 1'b1;
        end

        if (detect_add) begin
            err_d        = 1'b0;
            err_status_d = 2'b00;
        end else if (pd_rise) begin
            err_status_d[0] = (acc_q != chk_q);
            err_status_d[1] = (LEN_CHECK != 0) && (pay_cnt_q != hdr_q[DATA_W-1:ADDR_W]);
            err_d           = |err_status_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hdr_q           <= '0;
            hold_q          <= '0;
            acc_q           <= '0;
            chk_q           <= '0;
            dout_q          <= '0;
            parity_done_q   <= 1'b0;
            pd_prev_q       <= 1'b0;
            low_pkt_valid_q <= 1'b0;
            err_q           <= 1'b0;
            err_status_q    <= 2'b00;
            pay_cnt_q       <= '0;
        end else begin
            hdr_q           <= hdr_d;
            hold_q          <= hold_d;
            acc_q           <= acc_d;
            chk_q           <= chk_d;
            dout_q          <= dout_d;
            parity_done_q   <= parity_done_d;
            pd_prev_q       <= pd_prev_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            err_q           <= err_d;
            err_status_q    <= err_status_d;
            pay_cnt_q       <= pay_cnt_d;
        end
    end

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
    assign err           = err_q;
    assign err_status    = err_status_q;
    assign pay_cnt       = pay_cnt_q;

endmodule
